gemm_core: RTL and testbench



---
 rtl/gemm_core_if.sv | 37 +++
 rtl/gemm_core.sv | 253 +++++++++++++++++++++++++
 tb/tb_gemm_core.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gemm_core_if.sv
// gemm_core_if: instruction, uop and buffer-memory bus of the GEMM core.
//   master : the core side. It drives upc, the read addresses and the
//            accumulator/output write ports. It receives the instruction,
//            the uop and the read data.
//   slave  : the memory/controller side, with the opposite directions.
// Every memory behind this bus is synchronous with 1-cycle read latency.
interface gemm_core_if;
    logic [127:0]  insn;
    logic [31:0]   uop;
    logic [12:0]   upc;
    logic [11:0]   acc_mem_rd_addr;
    logic [511:0]  acc_mem_rd_data;
    logic [11:0]   acc_mem_wr_addr;
    logic [511:0]  acc_mem_wr_data;
    logic [63:0]   acc_mem_wr_we;
    logic [11:0]   inp_mem_rd_addr;
    logic [127:0]  inp_mem_rd_data;
    logic [10:0]   wgt_mem_rd_addr;
    logic [2047:0] wgt_mem_rd_data;
    logic [11:0]   out_mem_wr_addr;
    logic [127:0]  out_mem_wr_data;
    logic [31:0]   out_mem_wr_we;

    modport master (
        input  insn, uop, acc_mem_rd_data, inp_mem_rd_data, wgt_mem_rd_data,
        output upc, acc_mem_rd_addr, acc_mem_wr_addr, acc_mem_wr_data,
               acc_mem_wr_we, inp_mem_rd_addr, wgt_mem_rd_addr,
               out_mem_wr_addr, out_mem_wr_data, out_mem_wr_we
    );

    modport slave (
        output insn, uop, acc_mem_rd_data, inp_mem_rd_data, wgt_mem_rd_data,
        input  upc, acc_mem_rd_addr, acc_mem_wr_addr, acc_mem_wr_data,
               acc_mem_wr_we, inp_mem_rd_addr, wgt_mem_rd_addr,
               out_mem_wr_addr, out_mem_wr_data, out_mem_wr_we
    );
endinterface

// File: rtl/gemm_core.sv
// gemm_core: GEMM execution unit.
// It decodes a held 128-bit GEMM instruction and walks
// i_out { i_in { upc } } over a uop range. For each uop it computes one
// 16-lane int32 accumulator row:
//   acc[j] + sum_k inp[k]*w[j][k]
// or zero when reset_reg is set. The row goes back to the accumulator
// buffer, and its low bytes go to the output buffer.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-low reset; returns the FSM to IDLE and
//          clears every output
//   bus  : gemm_core_if.master, the instruction/uop/buffer-memory bus

// One output lane: a signed int8 dot product added to an int32 accumulator.
// The 32-bit result wraps; it is not saturated.
module gemm_lane (
    input  logic        clr,
    input  logic [31:0] acc,
    input  logic [127:0] inp,
    input  logic [127:0] wgt,
    output logic [31:0] res
);
    logic [31:0] sum;
    logic [31:0] a;
    logic [31:0] b;

    always_comb begin
        sum = acc;
        a   = '0;
        b   = '0;
        for (int k = 0; k < 16; k++) begin
            a   = {{24{inp[8*k+7]}}, inp[8*k +: 8]};
            b   = {{24{wgt[8*k+7]}}, wgt[8*k +: 8]};
            sum = sum + a * b;
        end
        res = clr ? '0 : sum;
    end
endmodule

module gemm_core #(
    parameter int NUM_LANES = 16,
    parameter int VEC_W     = 16
) (
    input  logic       clk,
    input  logic       rst,
    gemm_core_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_READ, S_EXEC, S_DONE
    } state_e;

    typedef struct packed {
        logic        reset_reg;
        logic [12:0] uop_bgn;
        logic [13:0] uop_end;
        logic [13:0] iter_out;
        logic [13:0] iter_in;
        logic [10:0] dst_out;
        logic [10:0] dst_in;
        logic [10:0] src_out;
        logic [10:0] src_in;
        logic [9:0]  wgt_out;
        logic [9:0]  wgt_in;
    } gemm_cfg_t;

    state_e    state_q, state_d;
    gemm_cfg_t cfg_q, cfg_d;
    logic [13:0]  i_out_q, i_out_d;
    logic [13:0]  i_in_q, i_in_d;
    logic [12:0]  upc_q, upc_d;
    logic [11:0]  acc_rd_addr_q, acc_rd_addr_d;
    logic [11:0]  inp_rd_addr_q, inp_rd_addr_d;
    logic [10:0]  wgt_rd_addr_q, wgt_rd_addr_d;
    logic [11:0]  wr_addr_q, wr_addr_d;
    logic [511:0] acc_wr_data_q, acc_wr_data_d;
    logic [127:0] out_wr_data_q, out_wr_data_d;
    logic         we_q, we_d;

    // Instruction fields. Dependency flags [6:3] and bit 127 carry no
    // meaning for this unit.
    gemm_cfg_t ins;
    logic      is_gemm;
    logic      ins_ok;
    logic      unused_insn;

    assign is_gemm     = (bus.insn[2:0] == 3'd2);
    assign unused_insn = ^{bus.insn[6:3], bus.insn[127]};

    always_comb begin
        ins.reset_reg = bus.insn[7];
        ins.uop_bgn   = bus.insn[20:8];
        ins.uop_end   = bus.insn[34:21];
        ins.iter_out  = bus.insn[48:35];
        ins.iter_in   = bus.insn[62:49];
        ins.dst_out   = bus.insn[73:63];
        ins.dst_in    = bus.insn[84:74];
        ins.src_out   = bus.insn[95:85];
        ins.src_in    = bus.insn[106:96];
        ins.wgt_out   = bus.insn[116:107];
        ins.wgt_in    = bus.insn[126:117];
    end

    assign ins_ok = (ins.iter_out != '0) && (ins.iter_in != '0) &&
                    ({1'b0, ins.uop_bgn} < ins.uop_end);

    // Buffer indices. Every product is formed at the port width, so the
    // result wraps modulo 2^width as the addressing requires.
    logic [11:0] acc_idx;
    logic [11:0] inp_idx;
    logic [10:0] wgt_idx;

    assign acc_idx = {1'b0, bus.uop[10:0]}
                   + i_out_q[11:0] * {1'b0, cfg_q.dst_out}
                   + i_in_q[11:0]  * {1'b0, cfg_q.dst_in};
    assign inp_idx = {1'b0, bus.uop[21:11]}
                   + i_out_q[11:0] * {1'b0, cfg_q.src_out}
                   + i_in_q[11:0]  * {1'b0, cfg_q.src_in};
    assign wgt_idx = {1'b0, bus.uop[31:22]}
                   + i_out_q[10:0] * {1'b0, cfg_q.wgt_out}
                   + i_in_q[10:0]  * {1'b0, cfg_q.wgt_in};

    // Lane array. Read data is valid during EXEC.
    logic [NUM_LANES-1:0][31:0] new_row;
    logic [NUM_LANES-1:0][7:0]  out_row;

    for (genvar j = 0; j < NUM_LANES; j++) begin : g_lane
        gemm_lane u_lane (
            .clr (cfg_q.reset_reg),
            .acc (bus.acc_mem_rd_data[32*j +: 32]),
            .inp (bus.inp_mem_rd_data[8*VEC_W-1:0]),
            .wgt (bus.wgt_mem_rd_data[128*j +: 128]),
            .res (new_row[j])
        );
        assign out_row[j] = new_row[j][7:0];
    end

    // Loop end tests. upc + 1 and i + 1 fit in 14 bits.
    logic [13:0] upc_nxt;
    logic [13:0] i_in_nxt;
    logic [13:0] i_out_nxt;

    assign upc_nxt   = {1'b0, upc_q} + 14'd1;
    assign i_in_nxt  = i_in_q + 14'd1;
    assign i_out_nxt = i_out_q + 14'd1;

    always_comb begin
        state_d       = state_q;
        cfg_d         = cfg_q;
        i_out_d       = i_out_q;
        i_in_d        = i_in_q;
        upc_d         = upc_q;
        acc_rd_addr_d = acc_rd_addr_q;
        inp_rd_addr_d = inp_rd_addr_q;
        wgt_rd_addr_d = wgt_rd_addr_q;
        wr_addr_d     = wr_addr_q;
        acc_wr_data_d = acc_wr_data_q;
        out_wr_data_d = out_wr_data_q;
        we_d          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (is_gemm) begin
                    if (ins_ok) begin
                        cfg_d   = ins;
                        i_out_d = '0;
                        i_in_d  = '0;
                        upc_d   = ins.uop_bgn;
                        state_d = S_FETCH;
                    end else begin
                        // An empty loop nest still has to pass through
                        // DONE, so a held instruction is consumed once.
                        state_d = S_DONE;
                    end
                end
            end
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                acc_rd_addr_d = acc_idx;
                inp_rd_addr_d = inp_idx;
                wgt_rd_addr_d = wgt_idx;
                state_d       = S_READ;
            end
            S_READ:   state_d = S_EXEC;
            S_EXEC: begin
                acc_wr_data_d = new_row;
                out_wr_data_d = out_row;
                wr_addr_d     = acc_rd_addr_q;
                we_d          = 1'b1;
                state_d       = S_FETCH;
                if (upc_nxt < cfg_q.uop_end) begin
                    upc_d = upc_nxt[12:0];
                end else if (i_in_nxt < cfg_q.iter_in) begin
                    i_in_d = i_in_nxt;
                    upc_d  = cfg_q.uop_bgn;
                end else if (i_out_nxt < cfg_q.iter_out) begin
                    i_in_d  = '0;
                    i_out_d = i_out_nxt;
                    upc_d   = cfg_q.uop_bgn;
                end else begin
                    i_in_d  = '0;
                    i_out_d = '0;
                    upc_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!is_gemm) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            cfg_q         <= '0;
            i_out_q       <= '0;
            i_in_q        <= '0;
            upc_q         <= '0;
            acc_rd_addr_q <= '0;
            inp_rd_addr_q <= '0;
            wgt_rd_addr_q <= '0;
            wr_addr_q     <= '0;
            acc_wr_data_q <= '0;
            out_wr_data_q <= '0;
            we_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            cfg_q         <= cfg_d;
            i_out_q       <= i_out_d;
            i_in_q        <= i_in_d;
            upc_q         <= upc_d;
            acc_rd_addr_q <= acc_rd_addr_d;
            inp_rd_addr_q <= inp_rd_addr_d;
            wgt_rd_addr_q <= wgt_rd_addr_d;
            wr_addr_q     <= wr_addr_d;
            acc_wr_data_q <= acc_wr_data_d;
            out_wr_data_q <= out_wr_data_d;
            we_q          <= we_d;
        end
    end

    assign bus.upc             = upc_q;
    assign bus.acc_mem_rd_addr = acc_rd_addr_q;
    assign bus.inp_mem_rd_addr = inp_rd_addr_q;
    assign bus.wgt_mem_rd_addr = wgt_rd_addr_q;
    assign bus.acc_mem_wr_addr = wr_addr_q;
    assign bus.acc_mem_wr_data = acc_wr_data_q;
    assign bus.acc_mem_wr_we   = {64{we_q}};
    assign bus.out_mem_wr_addr = wr_addr_q;
    assign bus.out_mem_wr_data = out_wr_data_q;
    assign bus.out_mem_wr_we   = {32{we_q}};
endmodule

// File: tb/tb_gemm_core.sv
// tb_gemm_core: directed test of gemm_core. The memory models are
// synchronous, with 1-cycle read latency. The accumulator RAM returns a
// uniform init value until an address has been written. Input and weight
// reads return uniform bytes set by each test.
module tb_gemm_core;
    logic clk;
    logic rst;
    gemm_core_if bus();

    gemm_core u_dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // memory models
    logic [31:0]  uop_mem [0:63];
    logic [511:0] acc_mem [0:4095];
    logic [4095:0] acc_vld;
    logic [31:0]  acc_init;
    logic [7:0]   inp_byte;
    logic [7:0]   wgt_byte;
    logic         mem_clr;

    always @(posedge clk) begin
        bus.uop             <= uop_mem[bus.upc[5:0]];
        bus.acc_mem_rd_data <= acc_vld[bus.acc_mem_rd_addr] ?
                               acc_mem[bus.acc_mem_rd_addr] : {16{acc_init}};
        bus.inp_mem_rd_data <= {16{inp_byte}};
        bus.wgt_mem_rd_data <= {256{wgt_byte}};
        if (mem_clr) begin
            acc_vld <= '0;
        end else if (bus.acc_mem_wr_we[0]) begin
            acc_mem[bus.acc_mem_wr_addr] <= bus.acc_mem_wr_data;
            acc_vld[bus.acc_mem_wr_addr] <= 1'b1;
        end
    end

    // write monitor
    int cyc = 0;
    int wr_cnt = 0;
    int last_cyc = 0;
    int bad_we = 0;
    int log_acc [0:1023];
    int log_inp [0:1023];
    int log_wgt [0:1023];
    logic [511:0] last_acc;
    logic [127:0] last_out;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst && (bus.acc_mem_wr_we != '0 || bus.out_mem_wr_we != '0)) begin
            if (bus.acc_mem_wr_we != {64{1'b1}} || bus.out_mem_wr_we != {32{1'b1}} ||
                bus.out_mem_wr_addr != bus.acc_mem_wr_addr)
                bad_we <= bad_we + 1;
            if (wr_cnt < 1024) begin
                log_acc[wr_cnt] <= int'(bus.acc_mem_wr_addr);
                log_inp[wr_cnt] <= int'(bus.inp_mem_rd_addr);
                log_wgt[wr_cnt] <= int'(bus.wgt_mem_rd_addr);
            end
            last_acc <= bus.acc_mem_wr_data;
            last_out <= bus.out_mem_wr_data;
            last_cyc <= cyc;
            wr_cnt   <= wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] mk_insn(input logic rr, input int bgn, input int en,
                                             input int io, input int ii,
                                             input int dfo, input int dfi,
                                             input int sfo, input int sfi,
                                             input int wfo, input int wfi);
        logic [127:0] v;
        v          = '0;
        v[2:0]     = 3'd2;
        v[7]       = rr;
        v[20:8]    = bgn[12:0];
        v[34:21]   = en[13:0];
        v[48:35]   = io[13:0];
        v[62:49]   = ii[13:0];
        v[73:63]   = dfo[10:0];
        v[84:74]   = dfi[10:0];
        v[95:85]   = sfo[10:0];
        v[106:96]  = sfi[10:0];
        v[116:107] = wfo[9:0];
        v[126:117] = wfi[9:0];
        return v;
    endfunction

    task automatic clr_acc();
        @(negedge clk) mem_clr = 1'b1;
        @(negedge clk) mem_clr = 1'b0;
    endtask

    // Issue and hold an instruction. Then check the write count, which must
    // not grow while the instruction is held. Also check the time from the
    // IDLE exit edge to the last write pulse. Finally drop the opcode.
    task automatic run_gemm(input string tag, input logic [127:0] ins, input int exp_n);
        int base;
        int t0;
        int guard;
        @(negedge clk);
        base     = wr_cnt;
        bus.insn = ins;
        t0       = cyc + 1;
        guard    = 0;
        while (wr_cnt < base + exp_n && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 3000) chk({tag, " timeout"}, wr_cnt - base, exp_n);
        repeat (20) @(negedge clk);
        chk({tag, " count"}, wr_cnt - base, exp_n);
        if (exp_n > 0) chk({tag, " latency"}, last_cyc - t0, 4 * exp_n);
        bus.insn = '0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int base;
        int bad;
        int io;
        int ii;
        rst      = 1'b0;
        bus.insn = '0;
        mem_clr  = 1'b0;
        acc_init = '0;
        inp_byte = '0;
        wgt_byte = '0;
        for (int i = 0; i < 64; i++) uop_mem[i] = '0;
        // wgt 2, inp 3, acc 7
        uop_mem[20] = {10'd2, 11'd3, 11'd7};

        repeat (3) @(negedge clk);
        chk("reset upc", bus.upc, 0);
        chk("reset we", {bus.acc_mem_wr_we, bus.out_mem_wr_we}, 0);
        chk("reset wdata", bus.acc_mem_wr_data, 0);
        rst = 1'b1;
        clr_acc();

        // single uop: 16 * (1*1) = 0x10
        inp_byte = 8'h01; wgt_byte = 8'h01; acc_init = 32'd0;
        base = wr_cnt;
        run_gemm("single", mk_insn(0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0), 1);
        chk("single acc", last_acc, {16{32'h0000_0010}});
        chk("single out", last_out, {16{8'h10}});
        chk("single addr", log_acc[base], 0);

        // two uops on the same row: the second must see the first write
        clr_acc();
        run_gemm("raw", mk_insn(0, 0, 2, 1, 1, 0, 0, 0, 0, 0, 0), 2);
        chk("raw acc", last_acc, {16{32'h0000_0020}});

        // signed: 5 + 16*(-1*2) = -27
        clr_acc();
        inp_byte = 8'hFF; wgt_byte = 8'h02; acc_init = 32'd5;
        run_gemm("signed", mk_insn(0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0), 1);
        chk("signed acc", last_acc, {16{32'hFFFF_FFE5}});
        chk("signed out", last_out, {16{8'hE5}});

        // reset_reg clears the row regardless of acc/inp/wgt
        clr_acc();
        inp_byte = 8'h01; wgt_byte = 8'h01; acc_init = 32'd5;
        run_gemm("rstreg", mk_insn(1, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0), 3);
        chk("rstreg acc", last_acc, 0);
        chk("rstreg out", last_out, 0);

        // uop fields plus outer factors, with index wrap on i_out=2
        clr_acc();
        base = wr_cnt;
        run_gemm("idx", mk_insn(0, 20, 21, 3, 1, 2047, 0, 5, 0, 1023, 0), 3);
        chk("idx0 acc", log_acc[base], 7);
        chk("idx0 inp", log_inp[base], 3);
        chk("idx0 wgt", log_wgt[base], 2);
        chk("idx1 acc", log_acc[base+1], 2054);
        chk("idx1 wgt", log_wgt[base+1], 1025);
        chk("idx2 acc wrap", log_acc[base+2], 5);
        chk("idx2 inp", log_inp[base+2], 13);
        chk("idx2 wgt wrap", log_wgt[base+2], 0);

        // full loop nest: 15 uops x 4 x 4
        clr_acc();
        acc_init = 32'd0;
        base = wr_cnt;
        run_gemm("loop", mk_insn(0, 1, 16, 4, 4, 1, 1, 4, 4, 4, 4), 240);
        chk("loop n90 acc", log_acc[base+90], 3);
        chk("loop n90 inp", log_inp[base+90], 12);
        chk("loop n90 wgt", log_wgt[base+90], 12);
        bad = 0;
        for (int n = 0; n < 240; n++) begin
            io = n / 60;
            ii = (n / 15) % 4;
            if (log_acc[base+n] != io + ii || log_inp[base+n] != 4 * (io + ii) ||
                log_wgt[base+n] != 4 * (io + ii)) bad++;
        end
        chk("loop addrs", bad, 0);

        // retrigger after dropping the opcode
        run_gemm("retrig", mk_insn(0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0), 1);

        // degenerate instructions produce no writes
        run_gemm("iter_in0", mk_insn(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0), 0);
        run_gemm("bgn_eq_end", mk_insn(0, 4, 4, 1, 1, 0, 0, 0, 0, 0, 0), 0);

        // asynchronous reset mid-run
        @(negedge clk);
        bus.insn = mk_insn(0, 1, 16, 4, 4, 1, 1, 4, 4, 4, 4);
        repeat (30) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst upc", bus.upc, 0);
        chk("midrst rd addr", {bus.acc_mem_rd_addr, bus.inp_mem_rd_addr, bus.wgt_mem_rd_addr}, 0);
        chk("midrst wr addr", {bus.acc_mem_wr_addr, bus.out_mem_wr_addr}, 0);
        chk("midrst acc data", bus.acc_mem_wr_data, 0);
        chk("midrst out data", bus.out_mem_wr_data, 0);
        chk("midrst we", {bus.acc_mem_wr_we, bus.out_mem_wr_we}, 0);
        bus.insn = '0;
        repeat (2) @(negedge clk);
        rst  = 1'b1;
        base = wr_cnt;
        repeat (40) @(negedge clk);
        chk("postrst idle", wr_cnt - base, 0);

        // the core recovers after reset
        clr_acc();
        inp_byte = 8'h01; wgt_byte = 8'h01; acc_init = 32'd0;
        run_gemm("recover", mk_insn(0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0), 1);
        chk("recover acc", last_acc, {16{32'h0000_0010}});

        chk("we shape", bad_we, 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
